// File: rtl/smg_pkg.sv
// Shared opcode, state and ALU-operation definitions for the parametrised accumulator CPU.
package smg_pkg;

  // Base opcodes live in the low nibble with all upper IR bits zero; HALT is the all-ones word.
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDAC = 4'd1,
    OP_STAC = 4'd2,
    OP_MVAC = 4'd3,
    OP_MOVR = 4'd4,
    OP_JUMP = 4'd5,
    OP_JMPZ = 4'd6,
    OP_JPNZ = 4'd7,
    OP_ADD  = 4'd8,
    OP_SUB  = 4'd9,
    OP_INAC = 4'd10,
    OP_CLAC = 4'd11,
    OP_AND  = 4'd12,
    OP_OR   = 4'd13,
    OP_XOR  = 4'd14,
    OP_NOT  = 4'd15
  } opcode_e;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_EXEC  = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_STORE = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;

  typedef enum logic [3:0] {
    ALU_NOP,
    ALU_MOVR,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_INAC,
    ALU_CLAC,
    ALU_NOT
  } alu_op_t;

endpackage

// File: rtl/smg_core_param_alu.sv
// Combinational accumulator ALU: produces the new AC value and its zero flag.
module smg_alu
  import smg_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_t           alu_op,
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] r,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = ac;
    case (alu_op)
      ALU_MOVR: result = r;
      ALU_ADD:  result = ac + r;
      ALU_SUB:  result = ac - r;
      ALU_AND:  result = ac & r;
      ALU_OR:   result = ac | r;
      ALU_XOR:  result = ac ^ r;
      ALU_INAC: result = ac + DATA_W'(1);
      ALU_CLAC: result = '0;
      ALU_NOT:  result = ~ac;
      default:  result = ac;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/smg_core_param.sv
// Multicycle accumulator CPU: FSM, register file and memory request mux with a req/ready port.
module smg_core_param
  import smg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] ac_value,
  output logic              halted,
  output logic              illegal_op
);

  localparam int NAB = ADDR_W / DATA_W;
  localparam int KW  = (NAB > 1) ? $clog2(NAB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NAB - 1);

  logic [2:0]        state, nxt_state;
  logic [ADDR_W-1:0] pc, nxt_pc, ar, nxt_ar;
  logic [DATA_W-1:0] ac, nxt_ac, r, nxt_r, ir, nxt_ir;
  logic              z, nxt_z;
  logic [KW-1:0]     k, nxt_k;

  logic              xfer, is_base, is_halt;
  opcode_e           op;
  alu_op_t           alu_op;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;

  logic              nxt_req, nxt_we;
  logic [ADDR_W-1:0] nxt_addr;

  assign xfer    = mem_req & mem_ready;
  assign op      = opcode_e'(ir[3:0]);
  assign is_base = (ir[DATA_W-1:4] == '0);
  assign is_halt = &ir;

  always_comb begin
    alu_op = ALU_NOP;
    if (is_base) begin
      case (op)
        OP_MOVR: alu_op = ALU_MOVR;
        OP_ADD:  alu_op = ALU_ADD;
        OP_SUB:  alu_op = ALU_SUB;
        OP_AND:  alu_op = ALU_AND;
        OP_OR:   alu_op = ALU_OR;
        OP_XOR:  alu_op = ALU_XOR;
        OP_INAC: alu_op = ALU_INAC;
        OP_CLAC: alu_op = ALU_CLAC;
        OP_NOT:  alu_op = ALU_NOT;
        default: alu_op = ALU_NOP;
      endcase
    end
  end

  smg_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_op (alu_op),
    .ac     (ac),
    .r      (r),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_comb begin
    nxt_state = state;
    nxt_pc    = pc;
    nxt_ar    = ar;
    nxt_ac    = ac;
    nxt_r     = r;
    nxt_ir    = ir;
    nxt_z     = z;
    nxt_k     = k;
    case (state)
      ST_FETCH: begin
        if (xfer) begin
          nxt_ir    = mem_rdata;
          nxt_pc    = pc + ADDR_W'(1);
          nxt_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        nxt_state = ST_FETCH;
        if (is_halt) begin
          nxt_state = ST_HALT;
        end else if (is_base) begin
          case (op)
            OP_LDAC, OP_STAC, OP_JUMP, OP_JMPZ, OP_JPNZ: begin
              nxt_k     = '0;
              nxt_state = ST_ADDR;
            end
            OP_NOP:  nxt_state = ST_FETCH;
            OP_MVAC: nxt_r = ac;
            default: begin
              nxt_ac = alu_res;
              nxt_z  = alu_zero;
            end
          endcase
        end
      end
      ST_ADDR: begin
        if (xfer) begin
          // Address bytes arrive little-endian; byte k lands in slice k of AR.
          nxt_ar[k*DATA_W +: DATA_W] = mem_rdata;
          nxt_pc = pc + ADDR_W'(1);
          nxt_k  = k + KW'(1);
          if (k == K_LAST) begin
            nxt_state = ST_FETCH;
            case (op)
              OP_LDAC: nxt_state = ST_LOAD;
              OP_STAC: nxt_state = ST_STORE;
              OP_JUMP: nxt_pc = nxt_ar;
              OP_JMPZ: if (z) nxt_pc = nxt_ar;
              OP_JPNZ: if (!z) nxt_pc = nxt_ar;
              default: nxt_state = ST_FETCH;
            endcase
          end
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          nxt_ac    = mem_rdata;
          nxt_z     = (mem_rdata == '0);
          nxt_state = ST_FETCH;
        end
      end
      ST_STORE: begin
        if (xfer) nxt_state = ST_FETCH;
      end
      ST_HALT: nxt_state = ST_HALT;
      default: nxt_state = ST_FETCH;
    endcase
  end

  // The request for the next state is registered so it is already up on that state's first cycle.
  always_comb begin
    nxt_req  = (nxt_state == ST_FETCH) || (nxt_state == ST_ADDR) ||
               (nxt_state == ST_LOAD)  || (nxt_state == ST_STORE);
    nxt_we   = (nxt_state == ST_STORE);
    nxt_addr = ((nxt_state == ST_LOAD) || (nxt_state == ST_STORE)) ? nxt_ar : nxt_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_FETCH;
      pc        <= '0;
      ar        <= '0;
      ac        <= '0;
      r         <= '0;
      ir        <= '0;
      z         <= 1'b1;
      k         <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= nxt_state;
      pc        <= nxt_pc;
      ar        <= nxt_ar;
      ac        <= nxt_ac;
      r         <= nxt_r;
      ir        <= nxt_ir;
      z         <= nxt_z;
      k         <= nxt_k;
      mem_req   <= nxt_req;
      mem_we    <= nxt_we;
      mem_addr  <= nxt_addr;
      mem_wdata <= nxt_ac;
    end
  end

  assign opcode     = ir;
  assign ac_value   = ac;
  assign halted     = (state == ST_HALT);
  assign illegal_op = (state == ST_EXEC) && !is_halt && !is_base;

endmodule

// File: tb/tb_smg_core_param.sv
// Bench for smg_core_param: an instruction-level model predicts every memory access of the 8-bit core.
module tb_smg_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic rst16 = 1'b1;

  logic        req8, we8, ready8, ill8, halted8;
  logic [15:0] addr8;
  logic [7:0]  wdata8, rdata8, op8, ac8;

  logic        req16, we16, ready16, ill16, halted16;
  logic [31:0] addr16;
  logic [15:0] wdata16, rdata16, op16, ac16;

  smg_core_param #(.DATA_W(8), .ADDR_W(16)) u8 (
    .clk(clk), .reset(reset), .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
    .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ready(ready8), .opcode(op8),
    .ac_value(ac8), .halted(halted8), .illegal_op(ill8)
  );

  smg_core_param #(.DATA_W(16), .ADDR_W(32)) u16 (
    .clk(clk), .reset(rst16), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
    .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ready(ready16), .opcode(op16),
    .ac_value(ac16), .halted(halted16), .illegal_op(ill16)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } acc_t;

  logic [7:0]  mem8 [0:65535];
  logic [7:0]  mm   [0:65535];
  logic [15:0] mem16 [logic [31:0]];
  acc_t        exp_q [$];
  int          xfer_cyc [$];

  int   n_vec = 0;
  int   n_err = 0;
  int   wait8 = 0;
  int   wcnt8 = 0;
  int   cyc8 = 0;
  int   ill_cnt8 = 0;
  int   stab_cnt = 0;
  bit   cmp_on = 0;
  bit   wait_prev8 = 0;
  bit   saw16 = 0;
  logic [15:0] prev_addr8;
  logic        prev_we8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic acc_t mk(input logic [15:0] a, input logic w, input logic [7:0] d);
    return '{addr: a, we: w, wdata: d};
  endfunction

  // 8-bit memory: programmable wait states, transfer compared against the model queue.
  always @(negedge clk) begin
    cyc8++;
    if (ill8) ill_cnt8++;
    if (wait_prev8 && req8) begin
      stab_cnt++;
      chk("addr_stable", addr8, prev_addr8);
      chk("we_stable", we8, prev_we8);
    end
    if (!req8) begin
      ready8 = 1'b0;
      wcnt8  = 0;
    end else if (wcnt8 < wait8) begin
      ready8 = 1'b0;
      wcnt8++;
    end else begin
      acc_t e;
      ready8 = 1'b1;
      wcnt8  = 0;
      rdata8 = mem8[addr8];
      if (we8) mem8[addr8] = wdata8;
      xfer_cyc.push_back(cyc8);
      if (cmp_on) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_access: addr 0x%0h we %0b beyond model sequence", addr8, we8);
        end else begin
          e = exp_q.pop_front();
          chk("acc_addr", addr8, e.addr);
          chk("acc_we", we8, e.we);
          if (e.we) chk("acc_wdata", wdata8, e.wdata);
        end
      end
    end
    wait_prev8 = req8 && !ready8;
    prev_addr8 = addr8;
    prev_we8   = we8;
  end

  always @(negedge clk) begin
    if (!req16) begin
      ready16 = 1'b0;
    end else begin
      ready16 = 1'b1;
      rdata16 = mem16.exists(addr16) ? mem16[addr16] : 16'h0;
      if (!we16 && addr16 == 32'h1234_5678) saw16 = 1'b1;
    end
  end

  // Instruction-level interpreter: produces the expected access list and final architectural state.
  task automatic model8(output logic [7:0] m_ac, output logic [15:0] m_hpc, output int m_ill);
    logic [15:0] pc, a;
    logic [7:0]  ac, r, op;
    logic        z;
    bit          done, upd;
    pc = 0; a = 0; ac = 0; r = 0; z = 1; done = 0; m_ill = 0; m_hpc = 0;
    mm = mem8;
    exp_q.delete();
    for (int n = 0; n < 500 && !done; n++) begin
      exp_q.push_back(mk(pc, 1'b0, 8'h00));
      op = mm[pc];
      m_hpc = pc;
      pc = pc + 16'd1;
      upd = 0;
      if (op inside {8'd1, 8'd2, 8'd5, 8'd6, 8'd7}) begin
        for (int b = 0; b < 2; b++) begin
          exp_q.push_back(mk(pc, 1'b0, 8'h00));
          a[8*b +: 8] = mm[pc];
          pc = pc + 16'd1;
        end
      end
      case (op)
        8'd0:  ;
        8'd1:  begin exp_q.push_back(mk(a, 1'b0, 8'h00)); ac = mm[a]; upd = 1; end
        8'd2:  begin exp_q.push_back(mk(a, 1'b1, ac)); mm[a] = ac; end
        8'd3:  r = ac;
        8'd4:  begin ac = r; upd = 1; end
        8'd5:  pc = a;
        8'd6:  if (z) pc = a;
        8'd7:  if (!z) pc = a;
        8'd8:  begin ac = ac + r; upd = 1; end
        8'd9:  begin ac = ac - r; upd = 1; end
        8'd10: begin ac = ac + 8'd1; upd = 1; end
        8'd11: begin ac = 8'd0; upd = 1; end
        8'd12: begin ac = ac & r; upd = 1; end
        8'd13: begin ac = ac | r; upd = 1; end
        8'd14: begin ac = ac ^ r; upd = 1; end
        8'd15: begin ac = ~ac; upd = 1; end
        8'hFF: done = 1;
        default: m_ill++;
      endcase
      if (upd) z = (ac == 8'd0);
    end
    m_ac = ac;
  endtask

  task automatic clear8();
    for (int i = 0; i < 65536; i++) mem8[i] = 8'h00;
  endtask

  task automatic load8(input logic [15:0] base, input logic [7:0] p [$]);
    for (int i = 0; i < p.size(); i++) mem8[base + 16'(i)] = p[i];
  endtask

  task automatic run8(input int wt, output logic [7:0] m_ac, output logic [15:0] m_hpc,
                      output int m_ill);
    model8(m_ac, m_hpc, m_ill);
    reset = 1'b0;
    wait8 = wt;
    @(negedge clk);
    @(negedge clk);
    xfer_cyc.delete();
    ill_cnt8 = 0;
    #2 reset = 1'b1;
    cmp_on = 1'b1;
    for (int c = 0; c < 2000 && !halted8; c++) @(negedge clk);
    chk("halted", halted8, 1);
    chk("access_seq_done", exp_q.size(), 0);
    chk("final_ac", ac8, m_ac);
    chk("illegal_count", ill_cnt8, m_ill);
    cmp_on = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  p [$];
    logic [7:0]  m_ac;
    logic [15:0] m_hpc;
    int          m_ill;

    ready8 = 0; rdata8 = 0; ready16 = 0; rdata16 = 0;
    clear8();
    mem16[32'h0] = 16'h0001;
    mem16[32'h1] = 16'h5678;
    mem16[32'h2] = 16'h1234;
    mem16[32'h3] = 16'h000A;
    mem16[32'h4] = 16'hFFFF;
    mem16[32'h1234_5678] = 16'hFFFF;

    #1 reset = 1'b0; rst16 = 1'b0;
    #11;
    chk("rst_req", req8, 0);
    chk("rst_we", we8, 0);
    chk("rst_halted", halted8, 0);
    chk("rst_illegal", ill8, 0);
    chk("rst_ac", ac8, 0);
    chk("rst_opcode", op8, 0);
    chk("rst_z", u8.z, 1);

    // Zero-wait arithmetic and store
    clear8();
    p = '{8'h0B, 8'h0A, 8'h03, 8'h08, 8'h02, 8'h00, 8'h01, 8'hFF};
    load8(16'h0000, p);
    run8(0, m_ac, m_hpc, m_ill);
    chk("t1_model_ac", m_ac, 8'h02);
    chk("t1_mem100", mem8[16'h0100], 8'h02);
    chk("t1_z", u8.z, 0);
    chk("t1_regop_cycles", xfer_cyc[2] - xfer_cyc[1], 2);
    chk("t1_stac_cycles", xfer_cyc[7] - xfer_cyc[4] + 1, 5);

    // Three wait states on every access of LDAC
    clear8();
    p = '{8'h01, 8'h00, 8'h02, 8'hFF};
    load8(16'h0000, p);
    mem8[16'h0200] = 8'h80;
    stab_cnt = 0;
    run8(3, m_ac, m_hpc, m_ill);
    chk("t2_model_ac", m_ac, 8'h80);
    chk("t2_ac", ac8, 8'h80);
    chk("t2_waits_seen", stab_cnt >= 12, 1);

    // Conditional jumps taken and untaken
    clear8();
    p = '{8'h06, 8'h10, 8'h00};       load8(16'h0000, p);
    p = '{8'h0A, 8'h05, 8'h20, 8'h00}; load8(16'h0010, p);
    p = '{8'h06, 8'h10, 8'h00, 8'h07, 8'h30, 8'h00}; load8(16'h0020, p);
    p = '{8'h0B, 8'h07, 8'h40, 8'h00, 8'hFF}; load8(16'h0030, p);
    run8(0, m_ac, m_hpc, m_ill);
    chk("t3_model_halt_pc", m_hpc, 16'h0034);
    chk("t3_model_ac", m_ac, 8'h00);

    // Undefined opcode behaves as NOP and flags once
    clear8();
    p = '{8'h0A, 8'h03, 8'h40, 8'h08, 8'hFF};
    load8(16'h0000, p);
    run8(1, m_ac, m_hpc, m_ill);
    chk("t4_model_ill", m_ill, 1);
    chk("t4_model_ac", m_ac, 8'h02);

    // Full ALU mix with loads and stores
    clear8();
    p = '{8'h01, 8'h00, 8'h01, 8'h03, 8'h01, 8'h01, 8'h01, 8'h0C, 8'h02, 8'h10, 8'h01,
          8'h0D, 8'h0E, 8'h0F, 8'h09, 8'h02, 8'h11, 8'h01, 8'h04, 8'hFF};
    load8(16'h0000, p);
    mem8[16'h0100] = 8'h5A;
    mem8[16'h0101] = 8'h0F;
    run8(2, m_ac, m_hpc, m_ill);
    chk("t7_model_ac", m_ac, 8'h5A);
    chk("t7_mem110", mem8[16'h0110], 8'h0A);
    chk("t7_mem111", mem8[16'h0111], 8'hA5);

    // Reset while a store is waiting
    clear8();
    p = '{8'h0A, 8'h02, 8'h00, 8'h01, 8'hFF};
    load8(16'h0000, p);
    reset = 1'b0;
    wait8 = 5;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int c = 0; c < 100 && !(req8 && we8); c++) @(negedge clk);
    chk("t5_store_waiting", req8 && we8, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_req_dropped", req8, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_no_write", mem8[16'h0100], 8'h00);
    #2 reset = 1'b1;
    #1;
    chk("t5_ac", ac8, 0);
    chk("t5_halted", halted8, 0);
    chk("t5_opcode", op8, 0);
    chk("t5_z", u8.z, 1);
    for (int c = 0; c < 10 && !req8; c++) @(negedge clk);
    chk("t5_first_req", req8, 1);
    chk("t5_first_addr", addr8, 16'h0000);
    chk("t5_first_we", we8, 0);
    reset = 1'b0;

    // Wide core: two-word little-endian address
    @(negedge clk);
    #2 rst16 = 1'b1;
    for (int c = 0; c < 200 && !halted16; c++) @(negedge clk);
    chk("t6_halted", halted16, 1);
    chk("t6_read_12345678", saw16, 1);
    chk("t6_ac", ac16, 16'h0000);
    chk("t6_z", u16.z, 1);
    chk("t6_illegal", ill16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
